// File: rtl/ram_iface_arbiter.sv
// rtl/ram_iface_arbiter.sv - round-robin arbiter sharing the RAM interface cache-side port
//
// Two cache requesters share one RAM interface port. Port 0 is the I-cache and
// port 1 is the D-cache. Only one transaction is outstanding at a time. The
// grant is held until the RAM interface acks. One dead cycle follows each
// transaction. All outputs are registered. Everything is in the cache clock
// domain.
//
// Ports
//   clk                 cache clock, posedge
//   not_reset           async reset, active-low
//   s0_* / s1_*         requester ports: avalid, rnw, addr, wdata in;
//                       rdata and 1-cycle ack out
//   m_*                 RAM interface side: avalid, rnw, addr, wdata out;
//                       rdata and 1-cycle ack in
//   grant               owner of the current or last transaction

module ram_iface_arbiter #(
  parameter int ADDR_SIZE      = 13,
  parameter int CASH_STR_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      not_reset,
  input  logic                      s0_avalid,
  input  logic                      s0_rnw,
  input  logic [ADDR_SIZE-1:0]      s0_addr,
  input  logic [CASH_STR_WIDTH-1:0] s0_wdata,
  output logic [CASH_STR_WIDTH-1:0] s0_rdata,
  output logic                      s0_ack,
  input  logic                      s1_avalid,
  input  logic                      s1_rnw,
  input  logic [ADDR_SIZE-1:0]      s1_addr,
  input  logic [CASH_STR_WIDTH-1:0] s1_wdata,
  output logic [CASH_STR_WIDTH-1:0] s1_rdata,
  output logic                      s1_ack,
  output logic                      m_avalid,
  output logic                      m_rnw,
  output logic [ADDR_SIZE-1:0]      m_addr,
  output logic [CASH_STR_WIDTH-1:0] m_wdata,
  input  logic [CASH_STR_WIDTH-1:0] m_rdata,
  input  logic                      m_ack,
  output logic                      grant
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                      rr_last, rr_last_nxt;
  logic                      pick;
  logic                      m_avalid_nxt, m_rnw_nxt, grant_nxt;
  logic [ADDR_SIZE-1:0]      m_addr_nxt;
  logic [CASH_STR_WIDTH-1:0] m_wdata_nxt;
  logic                      s0_ack_nxt, s1_ack_nxt;
  logic [CASH_STR_WIDTH-1:0] s0_rdata_nxt, s1_rdata_nxt;

  // On a tie the port that did not win last time is chosen. rr_last resets
  // to 1 so port 0 wins the first tie.
  always_comb begin
    if (s0_avalid && s1_avalid) begin
      pick = ~rr_last;
    end else begin
      pick = s1_avalid;
    end
  end

  // State register
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s0_avalid || s1_avalid) state_nxt = BUSY;
      BUSY:    if (m_ack) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. It computes the next value of every registered output.
  // Acks default to 0, so each ack is a single-cycle pulse.
  always_comb begin
    m_avalid_nxt = m_avalid;
    m_rnw_nxt    = m_rnw;
    m_addr_nxt   = m_addr;
    m_wdata_nxt  = m_wdata;
    grant_nxt    = grant;
    rr_last_nxt  = rr_last;
    s0_ack_nxt   = 1'b0;
    s1_ack_nxt   = 1'b0;
    s0_rdata_nxt = s0_rdata;
    s1_rdata_nxt = s1_rdata;
    case (state)
      IDLE: begin
        if (s0_avalid || s1_avalid) begin
          grant_nxt    = pick;
          rr_last_nxt  = pick;
          m_avalid_nxt = 1'b1;
          m_rnw_nxt    = pick ? s1_rnw   : s0_rnw;
          m_addr_nxt   = pick ? s1_addr  : s0_addr;
          m_wdata_nxt  = pick ? s1_wdata : s0_wdata;
        end
      end
      BUSY: begin
        // Requester inputs are deliberately not looked at here. The m_* side
        // keeps the values that were latched at grant time.
        if (m_ack) begin
          m_avalid_nxt = 1'b0;
          if (grant) begin
            s1_ack_nxt = 1'b1;
            if (m_rnw) s1_rdata_nxt = m_rdata;
          end else begin
            s0_ack_nxt = 1'b1;
            if (m_rnw) s0_rdata_nxt = m_rdata;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      m_avalid <= 1'b0;
      m_rnw    <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      grant    <= 1'b0;
      rr_last  <= 1'b1;
      s0_ack   <= 1'b0;
      s1_ack   <= 1'b0;
      s0_rdata <= '0;
      s1_rdata <= '0;
    end else begin
      m_avalid <= m_avalid_nxt;
      m_rnw    <= m_rnw_nxt;
      m_addr   <= m_addr_nxt;
      m_wdata  <= m_wdata_nxt;
      grant    <= grant_nxt;
      rr_last  <= rr_last_nxt;
      s0_ack   <= s0_ack_nxt;
      s1_ack   <= s1_ack_nxt;
      s0_rdata <= s0_rdata_nxt;
      s1_rdata <= s1_rdata_nxt;
    end
  end

endmodule
